// File: rtl/ism_pkg.sv
// Shared types and constants for the parametrised image sensor model.
package ism_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        ACTIVE = 3'd2,
        GAP    = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [1:0] MODE_RAMP    = 2'b00;
    localparam logic [1:0] MODE_DIAG    = 2'b01;
    localparam logic [1:0] MODE_CHECKER = 2'b10;
    localparam logic [1:0] MODE_LFSR    = 2'b11;

    localparam int unsigned LFSR_W = 16;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'h0001;
    // Fibonacci taps for x^16 + x^14 + x^13 + x^11 + 1 (state bits 15, 13, 12, 10)
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
        return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/ism_pattern_gen.sv
// Test-pattern mux for the image sensor model; owns the LFSR used by pattern 11.
module ism_pattern_gen
    import ism_pkg::*;
#(
    parameter int unsigned IMG_W = 64,
    parameter int unsigned PIX_W = 9,
    parameter int unsigned ROW_W = 3,
    parameter int unsigned COL_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic [ROW_W-1:0] row,
    input  logic [COL_W-1:0] col,
    input  logic             advance,
    input  logic             reseed,
    output logic [PIX_W-1:0] pixel
);

    logic [LFSR_W-1:0] lfsr_q;

    always_ff @(posedge clk) begin
        if (rst || reseed) begin
            lfsr_q <= LFSR_SEED;
        end else if (advance) begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    // Arithmetic patterns are computed wide and truncated to the pixel width.
    always_comb begin
        pixel = '0;
        case (mode)
            MODE_RAMP:    pixel = PIX_W'(32'(row) * IMG_W + 32'(col));
            MODE_DIAG:    pixel = PIX_W'(32'(row) + 32'(col));
            MODE_CHECKER: pixel = {PIX_W{row[0] ^ col[0]}};
            default:      pixel = lfsr_q[PIX_W-1:0];
        endcase
    end

endmodule

// File: rtl/image_sensor_model_gen.sv
// Parametrised image sensor model: pattern frames over a valid/ready pixel stream.
// Define ISM_OVERRUN_EN for a non-stalling sensor that drops refused pixels and flags out_overrun.
module image_sensor_model_gen
    import ism_pkg::*;
#(
    parameter int unsigned IMG_W     = 64,
    parameter int unsigned IMG_H     = 8,
    parameter int unsigned PIX_W     = 9,
    parameter int unsigned START_LAT = 4,
    parameter int unsigned LINE_GAP  = 2
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic             in_frame_capture,
    input  logic [1:0]       in_mode,
    input  logic             in_ready,
    output logic [PIX_W-1:0] out_data_read,
    output logic             out_valid,
    output logic             out_line_end,
    output logic             out_frame_end,
    output logic             out_done,
    output logic             out_busy,
`ifdef ISM_OVERRUN_EN
    output logic             out_overrun,
`endif
    output logic [7:0]       out_frame_cnt
);

    localparam int unsigned COL_W   = $clog2(IMG_W);
    localparam int unsigned ROW_W   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned CNT_MAX = (START_LAT > LINE_GAP) ? START_LAT : LINE_GAP;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    state_t             state_q, next_state;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         mode_q, mode_d;
    logic [PIX_W-1:0]   pixel_c, data_d;
    logic               valid_d, line_end_d, frame_end_d, done_d, busy_d;
    logic [7:0]         frame_cnt_d;
    logic               adv_c, load_c, capture_c, last_col_c, last_row_c;
`ifdef ISM_OVERRUN_EN
    logic               overrun_d;
`endif

    // row_q/col_q point at the next pixel to be loaded into the output register.
    assign capture_c  = (state_q == IDLE) && in_frame_capture;
    assign last_col_c = (col_q == COL_W'(IMG_W - 1));
    assign last_row_c = (row_q == ROW_W'(IMG_H - 1));
`ifdef ISM_OVERRUN_EN
    assign adv_c = out_valid;
`else
    assign adv_c = out_valid && in_ready;
`endif
    assign load_c = (next_state == ACTIVE) && (!out_valid || adv_c);

    ism_pattern_gen #(
        .IMG_W (IMG_W),
        .PIX_W (PIX_W),
        .ROW_W (ROW_W),
        .COL_W (COL_W)
    ) u_pattern (
        .clk     (in_clk),
        .rst     (in_rst),
        .mode    (mode_q),
        .row     (row_q),
        .col     (col_q),
        .advance (load_c),
        .reseed  (capture_c),
        .pixel   (pixel_c)
    );

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= next_state;
        end
    end

    always_comb begin
        next_state = state_q;
        case (state_q)
            IDLE:   if (in_frame_capture) next_state = START;
            START:  if (cnt_q == CNT_W'(START_LAT)) next_state = ACTIVE;
            ACTIVE: begin
                if (adv_c && out_line_end) begin
                    if (out_frame_end) begin
                        next_state = DONE;
                    end else if (LINE_GAP != 0) begin
                        next_state = GAP;
                    end
                end
            end
            GAP:    if (cnt_q == CNT_W'(LINE_GAP - 1)) next_state = ACTIVE;
            DONE:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Next values for the registered outputs and datapath.
    always_comb begin
        cnt_d       = '0;
        row_d       = row_q;
        col_d       = col_q;
        mode_d      = mode_q;
        data_d      = out_data_read;
        valid_d     = (next_state == ACTIVE);
        line_end_d  = valid_d ? out_line_end : 1'b0;
        frame_end_d = valid_d ? out_frame_end : 1'b0;
        done_d      = (next_state == DONE);
        busy_d      = (next_state != IDLE);
        frame_cnt_d = out_frame_cnt + 8'(done_d);
`ifdef ISM_OVERRUN_EN
        overrun_d   = capture_c ? 1'b0 : (out_overrun || (out_valid && !in_ready));
`endif
        if ((state_q == START || state_q == GAP) && next_state == state_q) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (capture_c) begin
            row_d  = '0;
            col_d  = '0;
            mode_d = in_mode;
        end
        if (load_c) begin
            data_d      = pixel_c;
            line_end_d  = last_col_c;
            frame_end_d = last_col_c && last_row_c;
            if (last_col_c) begin
                col_d = '0;
                row_d = last_row_c ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            row_q         <= '0;
            col_q         <= '0;
            cnt_q         <= '0;
            mode_q        <= MODE_RAMP;
            out_data_read <= '0;
            out_valid     <= 1'b0;
            out_line_end  <= 1'b0;
            out_frame_end <= 1'b0;
            out_done      <= 1'b0;
            out_busy      <= 1'b0;
            out_frame_cnt <= '0;
`ifdef ISM_OVERRUN_EN
            out_overrun   <= 1'b0;
`endif
        end else begin
            row_q         <= row_d;
            col_q         <= col_d;
            cnt_q         <= cnt_d;
            mode_q        <= mode_d;
            out_data_read <= data_d;
            out_valid     <= valid_d;
            out_line_end  <= line_end_d;
            out_frame_end <= frame_end_d;
            out_done      <= done_d;
            out_busy      <= busy_d;
            out_frame_cnt <= frame_cnt_d;
`ifdef ISM_OVERRUN_EN
            out_overrun   <= overrun_d;
`endif
        end
    end

endmodule

// File: tb/tb_image_sensor_model_gen.sv
// Bench for image_sensor_model_gen: frame scoreboard on a default instance plus a small LINE_GAP=0 instance.
`timescale 1ns/1ps
module tb_image_sensor_model_gen;

    localparam int W = 64, H = 8, N = W * H, LGAP = 2, LAT = 4;
`ifdef ISM_OVERRUN_EN
    localparam bit OVR = 1'b1;
`else
    localparam bit OVR = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // DUT A (default parameters)
    logic       rst, cap, ready_fix, rand_ready, rnd_bit, in_ready;
    logic [1:0] mode;
    logic [8:0] data;
    logic       valid, le, fe, done, busy;
    logic [7:0] fcnt;
`ifdef ISM_OVERRUN_EN
    logic       ovr, ovr_b;
`endif
    assign in_ready = rand_ready ? rnd_bit : ready_fix;

    // DUT B (4x2, back-to-back lines)
    logic       cap_b, rdy_b;
    logic [8:0] data_b;
    logic       valid_b, le_b, fe_b, done_b, busy_b;
    logic [7:0] fcnt_b;

    image_sensor_model_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(9), .START_LAT(LAT), .LINE_GAP(LGAP)) u_dut_a (
        .in_clk(clk), .in_rst(rst), .in_frame_capture(cap), .in_mode(mode), .in_ready(in_ready),
        .out_data_read(data), .out_valid(valid), .out_line_end(le), .out_frame_end(fe),
        .out_done(done), .out_busy(busy),
`ifdef ISM_OVERRUN_EN
        .out_overrun(ovr),
`endif
        .out_frame_cnt(fcnt));

    image_sensor_model_gen #(.IMG_W(4), .IMG_H(2), .PIX_W(9), .START_LAT(LAT), .LINE_GAP(0)) u_dut_b (
        .in_clk(clk), .in_rst(rst), .in_frame_capture(cap_b), .in_mode(2'b00), .in_ready(rdy_b),
        .out_data_read(data_b), .out_valid(valid_b), .out_line_end(le_b), .out_frame_end(fe_b),
        .out_done(done_b), .out_busy(busy_b),
`ifdef ISM_OVERRUN_EN
        .out_overrun(ovr_b),
`endif
        .out_frame_cnt(fcnt_b));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference pattern: pixel k of a frame in raster order, from the pattern rules.
    logic [15:0] lfsr_tab [N];
    function automatic logic [8:0] exp_pix(input logic [1:0] m, input int k);
        int r, c;
        r = k / W;
        c = k % W;
        case (m)
            2'b00:   return 9'(r * W + c);
            2'b01:   return 9'(r + c);
            2'b10:   return ((r ^ c) & 1) != 0 ? 9'h1FF : 9'h000;
            default: return lfsr_tab[k][8:0];
        endcase
    endfunction

    always @(posedge clk) begin
        #1 rnd_bit = 1'($urandom_range(0, 1));
    end

    // Scoreboard for DUT A, sampled on the falling edge.
    logic [1:0]  exp_mode = 2'b00;
    int          k = 0, last_k = 0, stalls = 0, gap_left = 0;
    logic [7:0]  exp_cnt = 8'd0;
    logic        done_due = 1'b0, gap_chk = 1'b0, stall_prev = 1'b0;
    logic [11:0] prev_out = '0;
    logic [8:0]  last_data = '0;
    logic [8:0]  rec [N];

    always @(negedge clk) begin
        if (rst) begin
            k = 0; exp_cnt = 8'd0; done_due = 1'b0; gap_left = 0; gap_chk = 1'b0; stall_prev = 1'b0;
        end else begin
            if (done_due) begin
                chk("done_pulse", 32'(done), 32'd1);
                chk("frame_cnt", 32'(fcnt), 32'(exp_cnt));
                done_due = 1'b0;
            end else begin
                chk("no_done", 32'(done), 32'd0);
            end
            if (gap_left > 0) begin
                chk("gap_low", 32'(valid), 32'd0);
                gap_left--;
                gap_chk = (gap_left == 0);
            end else if (gap_chk) begin
                chk("gap_end_valid", 32'(valid), 32'd1);
                gap_chk = 1'b0;
            end
            if (stall_prev) chk("stall_hold", 32'({valid, data, le, fe}), 32'(prev_out));
            if (valid && (in_ready || OVR)) begin
                chk("pix_data", 32'(data), 32'(exp_pix(exp_mode, k)));
                chk("line_end", 32'(le), 32'((k % W) == W - 1));
                chk("frame_end", 32'(fe), 32'(k == N - 1));
                rec[k] = data;
                last_data = data;
                if (k == N - 1) begin
                    last_k = N;
                    k = 0;
                    done_due = 1'b1;
                    exp_cnt = exp_cnt + 8'd1;
                end else begin
                    if ((k % W) == W - 1 && LGAP > 0) gap_left = LGAP;
                    k++;
                end
            end
            if (valid && !in_ready) stalls++;
            stall_prev = valid && !in_ready && !OVR;
            prev_out = {valid, data, le, fe};
        end
    end

    task automatic capture_a(input logic [1:0] m, output int lat, output logic [8:0] first);
        @(posedge clk); #1;
        exp_mode = m; mode = m; cap = 1'b1;
        @(posedge clk); #1;
        cap = 1'b0;
        lat = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (valid) break;
            @(posedge clk);
            lat++;
        end
        first = data;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (done) return;
        end
        tests++; fails++;
        $display("FAIL %s: no done pulse within 4000 cycles", name);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int lat, diffs, s0, nvalid, nruns, ndone, done_at, last_at;
        logic [8:0] first;
        logic [8:0] saved [N];
        logic pv;
        logic [15:0] v;

        v = 16'h0001;
        for (int i = 0; i < N; i++) begin
            lfsr_tab[i] = v;
            v = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
        end
        rst = 1'b1; cap = 1'b0; mode = 2'b00; ready_fix = 1'b1; rand_ready = 1'b0;
        cap_b = 1'b0; rdy_b = 1'b1;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_markers", 32'({le, fe}), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_cnt", 32'(fcnt), 32'd0);
        chk("rst_b_outputs", 32'({valid_b, done_b, busy_b, fcnt_b}), 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // pin the reference model with hand-computed values
        chk("pin_ramp_511", 32'(exp_pix(2'b00, 511)), 32'd511);
        chk("pin_diag_r1c6", 32'(exp_pix(2'b01, 70)), 32'd7);
        chk("pin_chk_r0c1", 32'(exp_pix(2'b10, 1)), 32'h1FF);
        chk("pin_chk_r1c1", 32'(exp_pix(2'b10, 65)), 32'h000);
        chk("pin_lfsr_0", 32'(exp_pix(2'b11, 0)), 32'h001);
        chk("pin_lfsr_11", 32'(exp_pix(2'b11, 11)), 32'h001);
        chk("pin_lfsr_13", 32'(exp_pix(2'b11, 13)), 32'h005);

        // ramp frame, always ready, mode pin changed mid-frame
        capture_a(2'b00, lat, first);
        chk("ramp_latency", 32'(lat), 32'd5);
        chk("ramp_first", 32'(first), 32'd0);
        chk("ramp_busy", 32'(busy), 32'd1);
        mode = 2'b11;
        wait_done("ramp_done");
        chk("ramp_frame_cnt", 32'(fcnt), 32'd1);
        chk("ramp_transfers", 32'(last_k), 32'd512);
        chk("ramp_last_data", 32'(last_data), 32'd511);
        @(negedge clk);
        chk("ramp_idle_busy", 32'(busy), 32'd0);

        // checkerboard under random backpressure
        s0 = stalls;
        rand_ready = 1'b1;
        capture_a(2'b10, lat, first);
        chk("chk_latency", 32'(lat), 32'd5);
        chk("chk_first", 32'(first), 32'd0);
        wait_done("checker_done");
        rand_ready = 1'b0;
        chk("chk_frame_cnt", 32'(fcnt), 32'd2);
        chk("chk_stalls_seen", 32'(stalls > s0), 32'd1);

        // LFSR, two frames must repeat
        capture_a(2'b11, lat, first);
        chk("lfsr_first", 32'(first), 32'h001);
        wait_done("lfsr_done_1");
        saved = rec;
        capture_a(2'b11, lat, first);
        chk("lfsr_first_2", 32'(first), 32'h001);
        wait_done("lfsr_done_2");
        diffs = 0;
        for (int i = 0; i < N; i++) if (saved[i] !== rec[i]) diffs++;
        chk("lfsr_repeat_diffs", 32'(diffs), 32'd0);
        chk("lfsr_frame_cnt", 32'(fcnt), 32'd4);

        // reset in row 3, then a fresh frame
        capture_a(2'b00, lat, first);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (valid && data == 9'd200) break;
        end
        chk("midrst_reached_row3", 32'(data), 32'd200);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid", 32'(valid), 32'd0);
        chk("midrst_data", 32'(data), 32'd0);
        chk("midrst_markers", 32'({le, fe}), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_frame_cnt", 32'(fcnt), 32'd0);
        repeat (5) @(negedge clk);
        chk("midrst_stays_idle", 32'(busy), 32'd0);
        capture_a(2'b00, lat, first);
        chk("restart_latency", 32'(lat), 32'd5);
        chk("restart_first", 32'(first), 32'd0);
        wait_done("restart_done");
        chk("restart_frame_cnt", 32'(fcnt), 32'd1);

        // small instance: 8 contiguous pixels, captures while busy ignored
        @(posedge clk); #1 cap_b = 1'b1;
        @(posedge clk); #1 cap_b = 1'b0;
        nvalid = 0; nruns = 0; ndone = 0; done_at = -1; last_at = -1; pv = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            cap_b = busy_b;
            if (valid_b) begin
                chk("b_data", 32'(data_b), 32'(nvalid));
                chk("b_line_end", 32'(le_b), 32'((nvalid % 4) == 3));
                chk("b_frame_end", 32'(fe_b), 32'(nvalid == 7));
                if (!pv) nruns++;
                nvalid++;
                last_at = i;
            end
            if (done_b) begin
                ndone++;
                done_at = i;
            end
            pv = valid_b;
        end
        cap_b = 1'b0;
        chk("b_valid_count", 32'(nvalid), 32'd8);
        chk("b_valid_runs", 32'(nruns), 32'd1);
        chk("b_done_count", 32'(ndone), 32'd1);
        chk("b_done_timing", 32'(done_at - last_at), 32'd1);
        chk("b_frame_cnt", 32'(fcnt_b), 32'd1);
        chk("b_idle", 32'(busy_b), 32'd0);

`ifdef ISM_OVERRUN_EN
        // non-stalling sensor drops refused pixels
        capture_a(2'b00, lat, first);
        chk("ovr_cleared", 32'(ovr), 32'd0);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (valid && data == 9'd20) break;
        end
        s0 = stalls;
        @(posedge clk); #1 ready_fix = 1'b0;
        repeat (3) @(posedge clk);
        #1 ready_fix = 1'b1;
        @(negedge clk);
        chk("ovr_drops", 32'(stalls - s0), 32'd3);
        chk("ovr_set", 32'(ovr), 32'd1);
        wait_done("ovr_done");
        chk("ovr_sticky", 32'(ovr), 32'd1);
        chk("ovr_frame_cnt", 32'(fcnt), 32'd2);
        capture_a(2'b00, lat, first);
        chk("ovr_capture_clears", 32'(ovr), 32'd0);
        wait_done("ovr_done_2");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
